// File: rtl/rank_match_scheduler.sv
// Sweeps one shared template-match engine over every rank kernel for a captured corner
// and reports the lowest-scoring kernel, or "no card" when even the best score is too high.
module rank_match_scheduler #(
    parameter int N_KERNELS     = 13,
    parameter int SCORE_W       = 11,
    parameter int REJECT_THRESH = 400,
    parameter int TIMEOUT       = 4095
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_corner_done,
    output logic                         o_match_start,
    output logic [$clog2(N_KERNELS)-1:0] o_kernel_sel,
    input  logic                         i_match_done,
    input  logic [SCORE_W-1:0]           i_match_score,
    output logic                         o_busy,
    output logic                         o_rank_valid,
    output logic [$clog2(N_KERNELS)-1:0] o_rank_id,
    output logic [SCORE_W-1:0]           o_rank_score,
    output logic                         o_no_card,
    output logic                         o_match_error,
    output logic                         o_overrun,
    output logic [2:0]                   o_state
);
    localparam int KW = $clog2(N_KERNELS);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [KW-1:0]      LAST_K = KW'(N_KERNELS - 1);
    localparam logic [CW-1:0]      TMO_M1 = CW'(TIMEOUT - 1);
    localparam logic [SCORE_W-1:0] THRESH = SCORE_W'(REJECT_THRESH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_ERROR = 3'd4
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [KW-1:0]        r_kernel_sel, w_kernel_nxt;
    logic [SCORE_W-1:0]   r_best_score, w_best_score_nxt;
    logic [KW-1:0]        r_best_id, w_best_id_nxt;
    logic [CW-1:0]        r_tmo_cnt, w_tmo_cnt_nxt;
    logic                 r_match_start, r_busy, r_rank_valid, r_no_card;
    logic                 r_match_error, r_overrun;
    logic [KW-1:0]        r_rank_id;
    logic [SCORE_W-1:0]   r_rank_score;

    // Engine handshake: match_start pulses once with kernel_sel already stable; kernel_sel
    // stays put until the engine answers with a one-cycle match_done carrying match_score.
    always_comb begin
        w_state_nxt      = r_state;
        w_kernel_nxt     = r_kernel_sel;
        w_best_score_nxt = r_best_score;
        w_best_id_nxt    = r_best_id;
        w_tmo_cnt_nxt    = r_tmo_cnt;
        case (r_state)
            S_IDLE: begin
                if (i_corner_done) begin
                    w_kernel_nxt     = '0;
                    w_best_score_nxt = '1;
                    w_best_id_nxt    = '0;
                    w_state_nxt      = S_START;
                end
            end
            S_START: begin
                w_tmo_cnt_nxt = '0;
                w_state_nxt   = S_WAIT;
            end
            S_WAIT: begin
                w_tmo_cnt_nxt = r_tmo_cnt + CW'(1);
                // A response on the final allowed cycle still counts as a result.
                if (i_match_done) begin
                    if (i_match_score < r_best_score) begin
                        w_best_score_nxt = i_match_score;
                        w_best_id_nxt    = r_kernel_sel;
                    end
                    if (r_kernel_sel == LAST_K) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_kernel_nxt = r_kernel_sel + KW'(1);
                        w_state_nxt  = S_START;
                    end
                end else if (r_tmo_cnt == TMO_M1) begin
                    w_state_nxt = S_ERROR;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            S_ERROR: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output flags are registered from the next state so they line up with the state itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_kernel_sel  <= '0;
            r_best_score  <= '1;
            r_best_id     <= '0;
            r_tmo_cnt     <= '0;
            r_match_start <= 1'b0;
            r_busy        <= 1'b0;
            r_rank_valid  <= 1'b0;
            r_rank_id     <= '0;
            r_rank_score  <= '0;
            r_no_card     <= 1'b0;
            r_match_error <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_kernel_sel  <= w_kernel_nxt;
            r_best_score  <= w_best_score_nxt;
            r_best_id     <= w_best_id_nxt;
            r_tmo_cnt     <= w_tmo_cnt_nxt;
            r_match_start <= (w_state_nxt == S_START);
            r_busy        <= (w_state_nxt != S_IDLE);
            r_rank_valid  <= (w_state_nxt == S_DONE);
            r_match_error <= (w_state_nxt == S_ERROR);
            if (w_state_nxt == S_DONE) begin
                r_rank_id    <= w_best_id_nxt;
                r_rank_score <= w_best_score_nxt;
                r_no_card    <= (w_best_score_nxt > THRESH);
            end
            if (i_corner_done && (r_state != S_IDLE)) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign o_match_start = r_match_start;
    assign o_kernel_sel  = r_kernel_sel;
    assign o_busy        = r_busy;
    assign o_rank_valid  = r_rank_valid;
    assign o_rank_id     = r_rank_id;
    assign o_rank_score  = r_rank_score;
    assign o_no_card     = r_no_card;
    assign o_match_error = r_match_error;
    assign o_overrun     = r_overrun;
    assign o_state       = r_state;

endmodule

// File: tb/tb_rank_match_scheduler.sv
// Bench for rank_match_scheduler: a scripted match engine, a vector table, randomized sweeps
// checked against a min-search model, and hand-written reset/overrun/timeout sequences.
module tb_rank_match_scheduler;
    localparam int NK  = 13;
    localparam int SW  = 11;
    localparam int TH  = 400;
    localparam int TMO = 50;
    localparam int KW  = $clog2(NK);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          corner_done = 1'b0;
    logic          match_done = 1'b0;
    logic [SW-1:0] match_score = '0;
    logic          match_start, busy, rank_valid, no_card, match_error, overrun;
    logic [KW-1:0] kernel_sel, rank_id;
    logic [SW-1:0] rank_score;
    logic [2:0]    dbg_state;

    always #5 clk = ~clk;

    rank_match_scheduler #(
        .N_KERNELS(NK), .SCORE_W(SW), .REJECT_THRESH(TH), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .i_corner_done(corner_done),
        .o_match_start(match_start),
        .o_kernel_sel(kernel_sel),
        .i_match_done(match_done),
        .i_match_score(match_score),
        .o_busy(busy),
        .o_rank_valid(rank_valid),
        .o_rank_id(rank_id),
        .o_rank_score(rank_score),
        .o_no_card(no_card),
        .o_match_error(match_error),
        .o_overrun(overrun),
        .o_state(dbg_state)
    );

    typedef struct {
        logic [SW-1:0] sc[NK];
        int            lat[NK];
        int            hang_k;
        int            exp_id;
        int            exp_score;
        int            exp_nc;
    } vec_t;

    vec_t          tbl[7];
    int            n_checks = 0;
    int            n_fail = 0;
    int            cyc = 0, cnt_ms = 0, cnt_rv = 0, cnt_err = 0;
    logic [SW-1:0] cur_sc[NK];
    int            cur_lat[NK];
    int            cur_hang, cur_inj, cur_rst_k;
    int            exp_id, exp_score, exp_nc;
    int            prev_id = 0, prev_score = 0, prev_nc = 0;

    // Pulse monitor, sampled after outputs settle following each rising edge.
    always @(posedge clk) begin
        #2;
        cyc++;
        if (match_start === 1'b1) cnt_ms++;
        if (rank_valid === 1'b1)  cnt_rv++;
        if (match_error === 1'b1) cnt_err++;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Best = smallest score; among equals the earliest kernel; reject above threshold.
    task automatic model();
        int q[$];
        for (int k = 0; k < NK; k++) q.push_back(int'(cur_sc[k]));
        q.sort();
        exp_score = q[0];
        exp_id = -1;
        for (int k = 0; k < NK; k++)
            if (exp_id < 0 && int'(cur_sc[k]) == exp_score) exp_id = k;
        exp_nc = (exp_score > TH) ? 1 : 0;
    endtask

    task automatic clear_modes();
        cur_hang = -1; cur_inj = -1; cur_rst_k = -1;
    endtask

    task automatic run_sweep();
        int t0, s, w, total, ms0, rv0, er0;
        ms0 = cnt_ms; rv0 = cnt_rv; er0 = cnt_err; total = 0;
        corner_done = 1'b1; t0 = cyc; tick(); corner_done = 1'b0;
        for (int k = 0; k < NK; k++) begin
            w = 0;
            while (match_start !== 1'b1 && w < 2 * TMO) begin tick(); w++; end
            chk("match_start_seen", match_start, 1);
            if (match_start !== 1'b1) return;
            chk("kernel_sel", kernel_sel, k);
            s = cyc;
            if (k == cur_rst_k) begin
                tick(); tick(); rst = 1'b1; tick(); rst = 1'b0;
                chk("rst_busy", busy, 0);
                chk("rst_match_start", match_start, 0);
                chk("rst_kernel_sel", kernel_sel, 0);
                chk("rst_rank_valid", rank_valid, 0);
                chk("rst_rank_id", rank_id, 0);
                chk("rst_rank_score", rank_score, 0);
                chk("rst_no_card", no_card, 0);
                chk("rst_match_error", match_error, 0);
                chk("rst_overrun", overrun, 0);
                tick();
                chk("rst_stays_idle", busy, 0);
                chk("rst_no_result", (cnt_rv - rv0) + (cnt_err - er0), 0);
                prev_id = 0; prev_score = 0; prev_nc = 0;
                return;
            end
            if (k == cur_hang) begin
                w = 0;
                while (match_error !== 1'b1 && w < 2 * TMO) begin tick(); w++; end
                chk("err_latency", cyc - s, TMO + 1);
                chk("err_no_valid", cnt_rv - rv0, 0);
                chk("err_starts", cnt_ms - ms0, k + 1);
                chk("err_keep_id", rank_id, prev_id);
                chk("err_keep_score", rank_score, prev_score);
                chk("err_keep_no_card", no_card, prev_nc);
                tick();
                chk("err_busy_drop", busy, 0);
                chk("err_pulse_once", cnt_err - er0, 1);
                return;
            end
            for (int i = 0; i < cur_lat[k]; i++) begin
                if (k == cur_inj && i == 0) corner_done = 1'b1;
                tick();
                corner_done = 1'b0;
            end
            match_done = 1'b1; match_score = cur_sc[k];
            tick();
            match_done = 1'b0; match_score = SW'($urandom);
            total += 1 + cur_lat[k];
        end
        w = 0;
        while (rank_valid !== 1'b1 && w < 20) begin tick(); w++; end
        chk("rank_valid", rank_valid, 1);
        chk("sweep_cycles", cyc - t0, total + 1);
        chk("rank_id", rank_id, exp_id);
        chk("rank_score", rank_score, exp_score);
        chk("no_card", no_card, exp_nc);
        chk("start_pulses", cnt_ms - ms0, NK);
        chk("valid_pulses", cnt_rv - rv0, 1);
        chk("error_pulses", cnt_err - er0, 0);
        prev_id = exp_id; prev_score = exp_score; prev_nc = exp_nc;
        tick();
        chk("post_busy", busy, 0);
        chk("post_rank_valid", rank_valid, 0);
    endtask

    initial begin
        // Vector table: hand-derived expectations.
        for (int v = 0; v < 7; v++) begin
            for (int k = 0; k < NK; k++) begin tbl[v].sc[k] = 11'd1000; tbl[v].lat[k] = 5; end
            tbl[v].hang_k = -1;
        end
        for (int k = 0; k < NK; k++) tbl[0].sc[k] = (k < 5) ? SW'(900 - 100 * k) : SW'(500 + 10 * k);
        tbl[0].sc[10] = 11'd37;
        tbl[0].exp_id = 10; tbl[0].exp_score = 37;   tbl[0].exp_nc = 0;
        tbl[1].sc[3] = 11'd401; tbl[1].sc[7] = 11'd401;
        tbl[1].exp_id = 3;  tbl[1].exp_score = 401;  tbl[1].exp_nc = 1;
        for (int k = 0; k < NK; k++) tbl[2].sc[k] = 11'h7FF;
        tbl[2].exp_id = 0;  tbl[2].exp_score = 2047; tbl[2].exp_nc = 1;
        for (int k = 0; k < NK; k++) tbl[3].sc[k] = 11'd401;
        tbl[3].sc[12] = 11'd400;
        tbl[3].exp_id = 12; tbl[3].exp_score = 400;  tbl[3].exp_nc = 0;
        tbl[4].sc[2] = 11'd3; tbl[4].lat[2] = TMO;
        tbl[4].exp_id = 2;  tbl[4].exp_score = 3;    tbl[4].exp_nc = 0;
        tbl[5].hang_k = 4;
        tbl[5].exp_id = 0;  tbl[5].exp_score = 0;    tbl[5].exp_nc = 0;
        tbl[6].sc[0] = 11'd0; tbl[6].sc[5] = 11'd0;
        tbl[6].exp_id = 0;  tbl[6].exp_score = 0;    tbl[6].exp_nc = 0;

        rst = 1'b1;
        repeat (3) tick();
        chk("reset_match_start", match_start, 0);
        chk("reset_kernel_sel", kernel_sel, 0);
        chk("reset_busy", busy, 0);
        chk("reset_rank_valid", rank_valid, 0);
        chk("reset_rank_id", rank_id, 0);
        chk("reset_rank_score", rank_score, 0);
        chk("reset_no_card", no_card, 0);
        chk("reset_match_error", match_error, 0);
        chk("reset_overrun", overrun, 0);
        chk("reset_state_idle", dbg_state, 0);
        rst = 1'b0;
        tick();

        for (int v = 0; v < 7; v++) begin
            clear_modes();
            cur_sc = tbl[v].sc; cur_lat = tbl[v].lat; cur_hang = tbl[v].hang_k;
            exp_id = tbl[v].exp_id; exp_score = tbl[v].exp_score; exp_nc = tbl[v].exp_nc;
            run_sweep();
        end

        // Randomized back-to-back sweeps, ties encouraged around the threshold.
        for (int r = 0; r < 20; r++) begin
            clear_modes();
            for (int k = 0; k < NK; k++) begin
                cur_sc[k]  = ($urandom_range(0, 2) == 0) ? SW'($urandom_range(395, 405))
                                                         : SW'($urandom_range(0, 2047));
                cur_lat[k] = $urandom_range(1, 6);
            end
            model();
            run_sweep();
        end
        chk("no_overrun_back_to_back", overrun, 0);

        // Reset during kernel 6, then a clean full sweep.
        clear_modes();
        for (int k = 0; k < NK; k++) begin cur_sc[k] = SW'($urandom_range(0, 2047)); cur_lat[k] = 3; end
        cur_rst_k = 6;
        run_sweep();
        clear_modes();
        model();
        run_sweep();

        // Stray match_done while idle, then a sweep with corner_done injected mid-sweep.
        match_done = 1'b1; match_score = '0;
        tick();
        match_done = 1'b0;
        tick();
        chk("stray_done_busy", busy, 0);
        chk("stray_done_start", match_start, 0);
        clear_modes();
        for (int k = 0; k < NK; k++) begin cur_sc[k] = SW'($urandom_range(100, 2047)); cur_lat[k] = 4; end
        cur_inj = 3;
        model();
        run_sweep();
        chk("overrun_set", overrun, 1);
        clear_modes();
        run_sweep();
        chk("overrun_sticky", overrun, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("overrun_cleared", overrun, 0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout, expected finish");
        $fatal(1, "bench time limit");
    end
endmodule

// File: doc/rank_match_scheduler.md
# rank_match_scheduler

Sequences a single shared XOR template-match engine across all rank kernels for one captured card corner. It selects the kernel with the lowest mismatch score and reports the winning rank, or "no card" when even the best score exceeds a reject threshold. It sits between the corner-capture logic, which pulses when a mask window is complete, and the downstream card/game logic that consumes rank results.

## Interface
Parameters:
- `N_KERNELS`, 13: number of rank templates (kernel index 0 = A … 12 = K).
- `SCORE_W`, 11: score width; must hold `corner_width*rank_height` (1120).
- `REJECT_THRESH`, 400: best score strictly above this value means no valid rank.
- `TIMEOUT`, 4095: maximum cycles spent waiting for `match_done` per kernel.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `corner_done`  in  1  one-cycle pulse: the mask window has been captured and a sweep can start.
- `match_start`  out  1  one-cycle pulse that starts the engine on `kernel_sel`.
- `kernel_sel`  out  $clog2(N_KERNELS)  kernel index the engine uses; held stable from `match_start` until `match_done`.
- `match_done`  in  1  one-cycle pulse from the engine; `match_score` is valid in the same cycle.
- `match_score`  in  SCORE_W  mismatch count for the current kernel.
- `busy`  out  1  high in every state except IDLE.
- `rank_valid`  out  1  one-cycle pulse; result outputs are valid in that cycle.
- `rank_id`  out  $clog2(N_KERNELS)  index of the winning kernel; held until the next result.
- `rank_score`  out  SCORE_W  winning score; held until the next result.
- `no_card`  out  1  qualified by `rank_valid`; 1 when `rank_score > REJECT_THRESH`.
- `match_error`  out  1  one-cycle pulse when a sweep is aborted on timeout.
- `overrun`  out  1  sticky flag; set when `corner_done` arrives while `busy`. Cleared only by `rst`.

## Operation
FSM states: IDLE, START, WAIT, DONE, ERROR.
- IDLE: on `corner_done`, clear `kernel_sel`, best_score (all ones) and best_id (0), then go to START.
- START: drive `match_start` = 1 for exactly one cycle, clear the timeout counter, go to WAIT.
- WAIT:
  - Increment the timeout counter each cycle.
  - On `match_done`: if `match_score < best_score` (strict), load best_score and best_id from this kernel. Ties keep the lower index.
  - After that update, if `kernel_sel == N_KERNELS-1`, go to DONE. Otherwise increment `kernel_sel` and go to START.
  - If `match_done` does not arrive and the counter reaches `TIMEOUT`, go to ERROR.
  - If `match_done` arrives in the same cycle the counter reaches `TIMEOUT`, `match_done` wins.
- DONE: pulse `rank_valid`. Drive `rank_id`/`rank_score` from best_id/best_score and `no_card = (best_score > REJECT_THRESH)`. Go to IDLE.
- ERROR: pulse `match_error`. Leave `rank_id`, `rank_score` and `no_card` unchanged. Go to IDLE.
- `match_done` is ignored in any state other than WAIT.
- `corner_done` in any state other than IDLE is dropped (the sweep is not restarted) and sets `overrun`.
- Compare arithmetic is unsigned and SCORE_W bits wide. A score of all ones can never win over the initial value, so if every kernel scores all ones, best_id = 0 and `no_card` = 1.

## Timing
- Reset values: `match_start` 0, `kernel_sel` 0, `busy` 0, `rank_valid` 0, `rank_id` 0, `rank_score` 0, `no_card` 0, `match_error` 0, `overrun` 0. FSM in IDLE.
- `rst` mid-sweep returns to IDLE on the next edge. No `rank_valid` or `match_error` is produced for the aborted sweep.
- `corner_done` at edge t: START during cycle t+1, so `match_start` is high in cycle t+1.
- Per kernel: 1 START cycle plus engine latency L, so `match_done` arrives at most L cycles after `match_start`.
- After the last `match_done` in cycle t, `rank_valid` is high in cycle t+1.
- Total sweep from `corner_done` to `rank_valid` = N_KERNELS·(1+L) + 1 cycles. With L = 1123 and N = 13, this is 14613 cycles, which fits inside the blanking interval for one frame.
- All outputs are registered; no combinational path from input to output.

## Test plan
- Nominal sweep: engine with fixed L=5 returns scores 900,800,…; kernel 10 returns 37, all others ≥ 500 → single `rank_valid`, `rank_id`=10, `rank_score`=37, `no_card`=0, exactly 13 `match_start` pulses, `rank_valid` 13·6+1 = 79 cycles after `corner_done`.
- Tie and reject: kernels 3 and 7 both return 401, all others 1000 → `rank_id`=3, `rank_score`=401, `no_card`=1.
- Timeout: engine never answers for kernel 4, with TIMEOUT=50 → `match_error` pulse exactly 50 WAIT cycles after the 5th `match_start`; no `rank_valid`; `busy` drops the next cycle; outputs keep the previous result.
- Overrun and spurious done: `corner_done` pulsed mid-sweep and `match_done` pulsed while in IDLE → sweep completes unchanged, `overrun` = 1 and stays 1 until `rst`; the stray `match_done` has no effect.
- Reset mid-sweep: `rst` during kernel 6 WAIT → next cycle `busy`=0, all outputs at reset values. A fresh `corner_done` then completes a full 13-kernel sweep normally.
- Back-to-back: `corner_done` in the cycle immediately after `rank_valid` (IDLE) → new sweep starts with `kernel_sel`=0; `overrun` stays 0.
